seq_miter_monitor: RTL and testbench

Parametrised, clocked equivalence monitor comparing gold and gate output vectors across several channels in simulation and emulation runs of the AES flow. It is the multi-channel successor to the single-bit combinational miter partitions. It registers and compares samples, and it ignores a programmable settle window after arming. It accumulates per-channel sticky failure flags, a mismatch count and a checked-cycle count, and reports a done/fail verdict through a small state machine.

---
 rtl/seq_miter_pkg.sv | 25 ++
 rtl/miter_lane_cmp.sv | 66 ++++++
 rtl/seq_miter_monitor.sv | 256 +++++++++++++++++++++++++
 tb/tb_seq_miter_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_miter_pkg.sv
// Shared types and helpers for the sequential miter monitor.
package seq_miter_pkg;

    // Monitor control states
    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCheck,
        StDrain,
        StDone
    } state_e;

    // Increment that sticks at the all-ones value of a width-bit counter (width <= 32)
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

    // LSB position of channel chan in a packed multi-channel bus
    function automatic int unsigned chan_lsb(input int unsigned chan, input int unsigned width);
        return chan * width;
    endfunction

endpackage

// File: rtl/miter_lane_cmp.sv
// One compare lane: stage 1 captures gold/gate/enable, stage 2 holds the masked mismatch.
// With SEQ_MITER_FIRST_FAIL_EN defined the stage-2 data is also kept for first-fail capture.
module miter_lane_cmp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] gold_i,
    input  logic [WIDTH-1:0] gate_i,
    input  logic             en_i,
    output logic             mismatch_o
`ifdef SEQ_MITER_FIRST_FAIL_EN
    ,
    output logic [WIDTH-1:0] gold_o,
    output logic [WIDTH-1:0] gate_o
`endif
);

    logic [WIDTH-1:0] gold_q, gate_q;
    logic             en_q;
    logic             mismatch_q;

    // Stage 1: capture the sample only when the monitor accepts it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gold_q <= '0;
            gate_q <= '0;
            en_q   <= 1'b0;
        end else if (load_i) begin
            gold_q <= gold_i;
            gate_q <= gate_i;
            en_q   <= en_i;
        end
    end

    // Stage 2: masked XOR-reduce; validity is tracked by the top level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= en_q & (|(gold_q ^ gate_q));
        end
    end

    assign mismatch_o = mismatch_q;

`ifdef SEQ_MITER_FIRST_FAIL_EN
    logic [WIDTH-1:0] gold_s2_q, gate_s2_q;

    // Stage 2 data copy, aligned with mismatch_q
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gold_s2_q <= '0;
            gate_s2_q <= '0;
        end else begin
            gold_s2_q <= gold_q;
            gate_s2_q <= gate_q;
        end
    end

    assign gold_o = gold_s2_q;
    assign gate_o = gate_s2_q;
`endif

endmodule

// File: rtl/seq_miter_monitor.sv
// Multi-channel clocked equivalence monitor: settle window, 2-stage compare pipeline,
// sticky per-channel fail flags and saturating statistics. CNT_W must not exceed 32.
// Optional first-failure capture outputs are enabled by defining SEQ_MITER_FIRST_FAIL_EN.
module seq_miter_monitor
    import seq_miter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SETTLE   = 2,
    localparam int unsigned CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      valid,
    input  logic [CHANNELS*WIDTH-1:0] gold_in,
    input  logic [CHANNELS*WIDTH-1:0] gate_in,
    input  logic [CHANNELS-1:0]       chan_en,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [CHANNELS-1:0]       fail_vec,
    output logic [CNT_W-1:0]          mismatch_cnt,
    output logic [CNT_W-1:0]          cycle_cnt
`ifdef SEQ_MITER_FIRST_FAIL_EN
    ,
    output logic [CHAN_W-1:0]         first_fail_chan,
    output logic [CNT_W-1:0]          first_fail_cycle,
    output logic [WIDTH-1:0]          first_gold,
    output logic [WIDTH-1:0]          first_gate
`endif
);

    localparam int unsigned SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e               state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic                 drain_q, drain_d;
    logic                 s1_valid_q, s2_valid_q;
    logic [CHANNELS-1:0]  fail_vec_q, fail_vec_d;
    logic [CNT_W-1:0]     mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic [CHANNELS-1:0]  mis_vec;
    logic                 any_mis;
    logic                 arm;
    logic                 capture;
    logic                 settle_last;

    // Arming is only honoured when idle or finished; stop wins over start while running
    assign arm         = start && ((state_q == StIdle) || (state_q == StDone));
    assign capture     = (state_q == StCheck) && valid && !stop;
    assign settle_last = (32'(settle_q) == (SETTLE - 32'd1));
    assign any_mis     = |mis_vec;

`ifdef SEQ_MITER_FIRST_FAIL_EN
    logic [WIDTH-1:0] lane_gold [CHANNELS];
    logic [WIDTH-1:0] lane_gate [CHANNELS];
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        miter_lane_cmp #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk_i      (clk),
            .rst_i      (rst),
            .load_i     (capture),
            .gold_i     (gold_in[chan_lsb(c, WIDTH) +: WIDTH]),
            .gate_i     (gate_in[chan_lsb(c, WIDTH) +: WIDTH]),
            .en_i       (chan_en[c]),
            .mismatch_o (mis_vec[c])
`ifdef SEQ_MITER_FIRST_FAIL_EN
            ,
            .gold_o     (lane_gold[c]),
            .gate_o     (lane_gate[c])
`endif
        );
    end

    // FSM state, settle counter and drain counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            settle_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            drain_q  <= drain_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        drain_d  = drain_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = (SETTLE > 0) ? StSettle : StCheck;
                    settle_d = '0;
                end
            end
            StSettle: begin
                if (stop) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end else if (valid) begin
                    if (settle_last) begin
                        state_d = StCheck;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                if (stop) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end
            end
            StDrain: begin
                // Two drain cycles let the last accepted sample reach the statistics
                if (drain_q) begin
                    state_d = StDone;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StSettle, StCheck, StDrain: busy = 1'b1;
            StDone:                     done = 1'b1;
            default:                    ;
        endcase
    end

    // Pipeline valid bits tracking samples through the lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= capture;
            s2_valid_q <= s1_valid_q;
        end
    end

    // Statistics next-state: clear on arm, otherwise update per checked sample
    always_comb begin
        fail_vec_d     = fail_vec_q;
        mismatch_cnt_d = mismatch_cnt_q;
        cycle_cnt_d    = cycle_cnt_q;
        if (arm) begin
            fail_vec_d     = '0;
            mismatch_cnt_d = '0;
            cycle_cnt_d    = '0;
        end else if (s2_valid_q) begin
            cycle_cnt_d = CNT_W'(sat_inc(32'(cycle_cnt_q), CNT_W));
            if (any_mis) begin
                mismatch_cnt_d = CNT_W'(sat_inc(32'(mismatch_cnt_q), CNT_W));
                fail_vec_d     = fail_vec_q | mis_vec;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_vec_q     <= '0;
            mismatch_cnt_q <= '0;
            cycle_cnt_q    <= '0;
        end else begin
            fail_vec_q     <= fail_vec_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            cycle_cnt_q    <= cycle_cnt_d;
        end
    end

    assign fail_vec     = fail_vec_q;
    assign fail         = |fail_vec_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign cycle_cnt    = cycle_cnt_q;

`ifdef SEQ_MITER_FIRST_FAIL_EN
    logic [CHAN_W-1:0] ff_chan_q, ff_chan_d;
    logic [CNT_W-1:0]  ff_cycle_q, ff_cycle_d;
    logic [WIDTH-1:0]  ff_gold_q, ff_gold_d;
    logic [WIDTH-1:0]  ff_gate_q, ff_gate_d;
    logic [CHAN_W-1:0] low_chan;
    logic [WIDTH-1:0]  low_gold, low_gate;

    // Lowest mismatching channel of the sample at stage 2
    always_comb begin
        low_chan = '0;
        low_gold = lane_gold[0];
        low_gate = lane_gate[0];
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (mis_vec[c]) begin
                low_chan = CHAN_W'(c);
                low_gold = lane_gold[c];
                low_gate = lane_gate[c];
            end
        end
    end

    // First-fail capture; an empty fail_vec means nothing was captured since arming
    always_comb begin
        ff_chan_d  = ff_chan_q;
        ff_cycle_d = ff_cycle_q;
        ff_gold_d  = ff_gold_q;
        ff_gate_d  = ff_gate_q;
        if (arm) begin
            ff_chan_d  = '0;
            ff_cycle_d = '0;
            ff_gold_d  = '0;
            ff_gate_d  = '0;
        end else if (s2_valid_q && any_mis && (fail_vec_q == '0)) begin
            ff_chan_d  = low_chan;
            ff_cycle_d = cycle_cnt_q;
            ff_gold_d  = low_gold;
            ff_gate_d  = low_gate;
        end
    end

    // First-fail registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_chan_q  <= '0;
            ff_cycle_q <= '0;
            ff_gold_q  <= '0;
            ff_gate_q  <= '0;
        end else begin
            ff_chan_q  <= ff_chan_d;
            ff_cycle_q <= ff_cycle_d;
            ff_gold_q  <= ff_gold_d;
            ff_gate_q  <= ff_gate_d;
        end
    end

    assign first_fail_chan  = ff_chan_q;
    assign first_fail_cycle = ff_cycle_q;
    assign first_gold       = ff_gold_q;
    assign first_gate       = ff_gate_q;
`endif

endmodule

// File: tb/tb_seq_miter_monitor.sv
// Directed self-checking bench for seq_miter_monitor (default and CNT_W=4 instances).
module tb_seq_miter_monitor;

    logic        clk = 1'b0;
    logic        rst, start, stop, valid;
    logic [31:0] gold_in, gate_in;
    logic [3:0]  chan_en;

    logic        busy, done, fail;
    logic [3:0]  fail_vec;
    logic [15:0] mismatch_cnt, cycle_cnt;
    logic        s_busy, s_done, s_fail;
    logic [3:0]  s_fail_vec;
    logic [3:0]  s_mismatch_cnt, s_cycle_cnt;
`ifdef SEQ_MITER_FIRST_FAIL_EN
    logic [1:0]  ff_chan, s_ff_chan;
    logic [15:0] ff_cycle;
    logic [3:0]  s_ff_cycle;
    logic [7:0]  ff_gold, ff_gate, s_ff_gold, s_ff_gate;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_miter_monitor #(.WIDTH(8), .CHANNELS(4), .CNT_W(16), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid),
        .gold_in(gold_in), .gate_in(gate_in), .chan_en(chan_en),
        .busy(busy), .done(done), .fail(fail), .fail_vec(fail_vec),
        .mismatch_cnt(mismatch_cnt), .cycle_cnt(cycle_cnt)
`ifdef SEQ_MITER_FIRST_FAIL_EN
        , .first_fail_chan(ff_chan), .first_fail_cycle(ff_cycle),
        .first_gold(ff_gold), .first_gate(ff_gate)
`endif
    );

    seq_miter_monitor #(.WIDTH(8), .CHANNELS(4), .CNT_W(4), .SETTLE(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid),
        .gold_in(gold_in), .gate_in(gate_in), .chan_en(chan_en),
        .busy(s_busy), .done(s_done), .fail(s_fail), .fail_vec(s_fail_vec),
        .mismatch_cnt(s_mismatch_cnt), .cycle_cnt(s_cycle_cnt)
`ifdef SEQ_MITER_FIRST_FAIL_EN
        , .first_fail_chan(s_ff_chan), .first_fail_cycle(s_ff_cycle),
        .first_gold(s_ff_gold), .first_gate(s_ff_gate)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'h1234_5678 + 32'(k) * 32'h0101_0101;
    endfunction

    task automatic send(input logic [31:0] g, input logic [31:0] t, input logic [3:0] en);
        valid = 1'b1; gold_in = g; gate_in = t; chan_en = en;
        tick();
        valid = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic end_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; valid = 1'b0;
        gold_in = '0; gate_in = '0; chan_en = 4'hF;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
        n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset fail: got %b want 0", fail); end
        n_checks++; if (fail_vec !== 4'b0) begin n_fail++; $display("FAIL reset fail_vec: got %b want 0000", fail_vec); end
        n_checks++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL reset mismatch_cnt: got %0d want 0", mismatch_cnt); end
        n_checks++; if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL reset cycle_cnt: got %0d want 0", cycle_cnt); end
    endtask

    task automatic test_clean();
        arm();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clean busy_after_start: got %b want 1", busy); end
        for (int k = 0; k < 10; k++) send(pat(k), pat(k), 4'hF);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clean done_early: got %b want 0", done); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clean done_3_edges: got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clean busy_at_done: got %b want 0", busy); end
        n_checks++; if (cycle_cnt !== 16'd8) begin n_fail++; $display("FAIL clean cycle_cnt: got %0d want 8", cycle_cnt); end
        n_checks++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL clean mismatch_cnt: got %0d want 0", mismatch_cnt); end
        n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL clean fail: got %b want 0", fail); end
    endtask

    task automatic test_single_flip();
        logic [31:0] g;
        arm();
        send(pat(100), pat(100), 4'hF);
        send(pat(101), pat(101), 4'hF);
        for (int k = 0; k < 10; k++) begin
            g = pat(k);
            // bit 3 of channel 2 on the 5th checked sample
            send(g, (k == 4) ? (g ^ 32'h0008_0000) : g, 4'hF);
        end
        end_run();
        n_checks++; if (fail_vec !== 4'b0100) begin n_fail++; $display("FAIL flip fail_vec: got %b want 0100", fail_vec); end
        n_checks++; if (mismatch_cnt !== 16'd1) begin n_fail++; $display("FAIL flip mismatch_cnt: got %0d want 1", mismatch_cnt); end
        n_checks++; if (cycle_cnt !== 16'd10) begin n_fail++; $display("FAIL flip cycle_cnt: got %0d want 10", cycle_cnt); end
        n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL flip fail: got %b want 1", fail); end
`ifdef SEQ_MITER_FIRST_FAIL_EN
        n_checks++; if (ff_chan !== 2'd2) begin n_fail++; $display("FAIL flip first_fail_chan: got %0d want 2", ff_chan); end
        n_checks++; if (ff_cycle !== 16'd4) begin n_fail++; $display("FAIL flip first_fail_cycle: got %0d want 4", ff_cycle); end
        n_checks++; if (ff_gold !== 8'h38) begin n_fail++; $display("FAIL flip first_gold: got %h want 38", ff_gold); end
        n_checks++; if (ff_gate !== 8'h30) begin n_fail++; $display("FAIL flip first_gate: got %h want 30", ff_gate); end
`endif
    endtask

    task automatic test_mask();
        logic [31:0] g;
        arm();
        n_checks++; if (fail_vec !== 4'b0) begin n_fail++; $display("FAIL mask cleared_by_start: got %b want 0000", fail_vec); end
        send(pat(100), pat(100), 4'b1011);
        send(pat(101), pat(101), 4'b1011);
        for (int k = 0; k < 10; k++) begin
            g = pat(k);
            send(g, (k == 4) ? (g ^ 32'h0008_0000) : g, 4'b1011);
        end
        end_run();
        n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL mask fail: got %b want 0", fail); end
        n_checks++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL mask mismatch_cnt: got %0d want 0", mismatch_cnt); end
        n_checks++; if (cycle_cnt !== 16'd10) begin n_fail++; $display("FAIL mask cycle_cnt: got %0d want 10", cycle_cnt); end
`ifdef SEQ_MITER_FIRST_FAIL_EN
        n_checks++; if (ff_cycle !== 16'd0) begin n_fail++; $display("FAIL mask first_fail_cycle: got %0d want 0", ff_cycle); end
`endif
    endtask

    task automatic test_settle();
        arm();
        send(pat(0), ~pat(0), 4'hF);
        send(pat(1), ~pat(1), 4'hF);
        for (int k = 2; k < 8; k++) send(pat(k), pat(k), 4'hF);
        end_run();
        n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL settle fail: got %b want 0", fail); end
        n_checks++; if (cycle_cnt !== 16'd6) begin n_fail++; $display("FAIL settle cycle_cnt: got %0d want 6", cycle_cnt); end
    endtask

    task automatic test_saturation();
        arm();
        send(pat(0), pat(0), 4'hF);
        send(pat(1), pat(1), 4'hF);
        for (int k = 0; k < 20; k++) send(pat(k), ~pat(k), 4'hF);
        end_run();
        n_checks++; if (s_mismatch_cnt !== 4'd15) begin n_fail++; $display("FAIL sat mismatch_cnt: got %0d want 15", s_mismatch_cnt); end
        n_checks++; if (s_cycle_cnt !== 4'd15) begin n_fail++; $display("FAIL sat cycle_cnt: got %0d want 15", s_cycle_cnt); end
        n_checks++; if (mismatch_cnt !== 16'd20) begin n_fail++; $display("FAIL sat wide_mismatch_cnt: got %0d want 20", mismatch_cnt); end
        n_checks++; if (fail_vec !== 4'b1111) begin n_fail++; $display("FAIL sat fail_vec: got %b want 1111", fail_vec); end
    endtask

    task automatic test_rst_mid();
        arm();
        send(pat(0), pat(0), 4'hF);
        send(pat(1), pat(1), 4'hF);
        for (int k = 0; k < 3; k++) send(pat(k), ~pat(k), 4'hF);
        tick(); tick();
        n_checks++; if (cycle_cnt !== 16'd3) begin n_fail++; $display("FAIL rst_mid pre_cycle_cnt: got %0d want 3", cycle_cnt); end
        n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL rst_mid pre_fail: got %b want 1", fail); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", busy); end
        n_checks++; if (fail_vec !== 4'b0) begin n_fail++; $display("FAIL rst_mid fail_vec: got %b want 0000", fail_vec); end
        n_checks++; if ({mismatch_cnt, cycle_cnt} !== 32'd0) begin n_fail++; $display("FAIL rst_mid counters: got %0d/%0d want 0/0", mismatch_cnt, cycle_cnt); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start_stop_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL stop_idle busy_done: got %b want 00", {busy, done}); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_stop_idle busy: got %b want 1", busy); end
        send(pat(0), pat(0), 4'hF);
        send(pat(1), pat(1), 4'hF);
        send(pat(2), pat(2), 4'hF);
        // start+stop while checking: stop wins
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick(); tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL start_stop_check done: got %b want 1", done); end
        n_checks++; if (cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL start_stop_check cycle_cnt: got %0d want 1", cycle_cnt); end
    endtask

    task automatic test_stop_inflight();
        arm();
        send(pat(0), pat(0), 4'hF);
        send(pat(1), pat(1), 4'hF);
        send(pat(2), pat(2) ^ 32'h0000_0001, 4'hF);
        // sample presented in the stop cycle must be ignored
        valid = 1'b1; gold_in = pat(3); gate_in = pat(3) ^ 32'h8000_0000; stop = 1'b1;
        tick();
        valid = 1'b0; stop = 1'b0;
        tick(); tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL inflight done: got %b want 1", done); end
        n_checks++; if (fail_vec !== 4'b0001) begin n_fail++; $display("FAIL inflight fail_vec: got %b want 0001", fail_vec); end
        n_checks++; if (cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL inflight cycle_cnt: got %0d want 1", cycle_cnt); end
        n_checks++; if (mismatch_cnt !== 16'd1) begin n_fail++; $display("FAIL inflight mismatch_cnt: got %0d want 1", mismatch_cnt); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_flip();
        test_mask();
        test_settle();
        test_saturation();
        test_rst_mid();
        test_start_stop_idle();
        test_stop_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
